access_guard_ctrl: RTL and testbench

- Parametrised successor to the single-ID access checker.
- Compares a requested ID against a table of NUM_IDS programmable, individually enabled IDs, using a valid/ready request handshake and a one-cycle response pulse.
- Counts consecutive denials. At FAIL_LIMIT it raises a sticky interrupt and locks out new requests for LOCK_CYCLES cycles.
- Sits between the host ID-request path and the protected resource's enable logic.

---
 rtl/access_guard_ctrl.sv | 116 +++++++++++
 tb/tb_access_guard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/access_guard_ctrl.sv
// ID access guard: checks a requested ID against a table of enabled IDs.
// Consecutive denials are counted, and reaching the limit raises irq and starts a timed lockout.
module access_guard_ctrl #(
  parameter  int ID_W        = 32,
  parameter  int NUM_IDS     = 4,
  parameter  int FAIL_LIMIT  = 3,
  parameter  int LOCK_CYCLES = 16,
  localparam int IDX_W       = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
  localparam int FC_W        = $clog2(FAIL_LIMIT + 1),
  localparam int LC_W        = $clog2(LOCK_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IDS*ID_W-1:0] id_table,
  input  logic [NUM_IDS-1:0]      id_enable,
  input  logic                    req_valid,
  input  logic [ID_W-1:0]         req_id,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic                    resp_granted,
  output logic                    resp_denied,
  output logic [IDX_W-1:0]        resp_index,
  output logic [FC_W-1:0]         fail_count,
  output logic                    locked,
  output logic                    irq,
  input  logic                    irq_clear
);

  typedef enum logic [1:0] {IDLE, CHECK, LOCKED} state_t;

  state_t             state, state_next;
  logic [ID_W-1:0]    id_cap;
  logic [NUM_IDS-1:0] en_cap;
  logic [LC_W-1:0]    lock_timer;
  logic [NUM_IDS-1:0] match;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               last_fail;
  logic               enter_lock;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IDS; gi++) begin : g_match
      assign match[gi] = en_cap[gi] && (id_table[gi*ID_W +: ID_W] == id_cap);
    end
  endgenerate

  // Scan from the top down so the lowest matching entry is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign last_fail  = (({1'b0, fail_count} + 1'b1) == (FC_W + 1)'(FAIL_LIMIT));
  assign enter_lock = (state == CHECK) && !hit && last_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = CHECK;
      CHECK:   state_next = enter_lock ? LOCKED : IDLE;
      LOCKED:  if (lock_timer == LC_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    locked    = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_cap       <= '0;
      en_cap       <= '0;
      lock_timer   <= '0;
      fail_count   <= '0;
      resp_valid   <= 1'b0;
      resp_granted <= 1'b0;
      resp_denied  <= 1'b0;
      resp_index   <= '0;
      irq          <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        id_cap <= req_id;
        en_cap <= id_enable;
      end
      if (state == CHECK) begin
        resp_valid   <= 1'b1;
        resp_granted <= hit;
        resp_denied  <= !hit;
        resp_index   <= hit ? hit_idx : '0;
        if (hit || last_fail) fail_count <= '0;
        else                  fail_count <= fail_count + 1'b1;
        if (enter_lock) lock_timer <= LC_W'(LOCK_CYCLES);
      end
      if (state == LOCKED) lock_timer <= lock_timer - 1'b1;
      // A new lockout outranks a simultaneous clear.
      if (enter_lock)     irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_access_guard_ctrl.sv
// Directed bench for access_guard_ctrl: vector table for single requests plus
// hand-written lockout, irq and reset sequences.
module tb_access_guard_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] id_table;
  logic [3:0]   id_enable;
  logic         req_valid;
  logic [31:0]  req_id;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_granted;
  logic         resp_denied;
  logic [1:0]   resp_index;
  logic [1:0]   fail_count;
  logic         locked;
  logic         irq;
  logic         irq_clear;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  access_guard_ctrl dut (
    .clk(clk), .rst(rst), .id_table(id_table), .id_enable(id_enable),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_granted(resp_granted), .resp_denied(resp_denied),
    .resp_index(resp_index), .fail_count(fail_count), .locked(locked),
    .irq(irq), .irq_clear(irq_clear)
  );

  typedef struct {
    logic [127:0] tbl;
    logic [3:0]   en;
    logic [31:0]  id;
    logic         g;
    logic         d;
    logic [1:0]   idx;
    logic [1:0]   fc;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [127:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_granted"}, resp_granted, 0);
    chk({tag, "_denied"}, resp_denied, 0);
    chk({tag, "_index"}, resp_index, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  // Called just after a rising edge with the block idle.
  task automatic do_req(input logic [31:0] id, input logic g, input logic d,
                        input logic [1:0] idx, input logic [1:0] fc,
                        input bit hold, input bit clr_in_check);
    req_valid = 1'b1;
    req_id    = id;
    chk("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (clr_in_check) irq_clear = 1'b1;
    chk("ready_in_check", req_ready, 0);
    chk("no_early_resp", resp_valid, 0);
    @(posedge clk); #1;
    irq_clear = 1'b0;
    $display("req id=%h -> valid=%0b granted=%0b denied=%0b index=%0d fail_count=%0d irq=%0b locked=%0b",
             id, resp_valid, resp_granted, resp_denied, resp_index, fail_count, irq, locked);
    chk("resp_valid", resp_valid, 1);
    chk("resp_granted", resp_granted, g);
    chk("resp_denied", resp_denied, d);
    chk("resp_index", resp_index, idx);
    chk("fail_count", fail_count, fc);
    if (hold) begin
      @(posedge clk); #1;
      chk("resp_valid_pulse", resp_valid, 0);
      chk("hold_granted", resp_granted, g);
      chk("hold_denied", resp_denied, d);
      chk("hold_index", resp_index, idx);
    end
  endtask

  initial begin
    int lock_n;
    int extra;
    int busy;
    logic [127:0] base;

    base = pack4(32'hA, 32'hB, 32'hC, 32'hD);
    vecs[0] = '{base, 4'hF, 32'hC, 1'b1, 1'b0, 2'd2, 2'd0};
    vecs[1] = '{base, 4'hD, 32'hB, 1'b0, 1'b1, 2'd0, 2'd1};
    vecs[2] = '{base, 4'hF, 32'hA, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[3] = '{pack4(32'h55, 32'hB, 32'hC, 32'h55), 4'hF, 32'h55, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[4] = '{base, 4'h0, 32'hA, 1'b0, 1'b1, 2'd0, 2'd1};
    vecs[5] = '{base, 4'h8, 32'hD, 1'b1, 1'b0, 2'd3, 2'd0};
    vecs[6] = '{base, 4'hF, 32'h12345678, 1'b0, 1'b1, 2'd0, 2'd1};
    vecs[7] = '{base, 4'hF, 32'h12345678, 1'b0, 1'b1, 2'd0, 2'd2};
    vecs[8] = '{base, 4'h2, 32'hB, 1'b1, 1'b0, 2'd1, 2'd0};

    rst = 1'b1; req_valid = 1'b0; req_id = '0; irq_clear = 1'b0;
    id_table = base; id_enable = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    chk("ready_after_reset", req_ready, 1);

    foreach (vecs[i]) begin
      id_table  = vecs[i].tbl;
      id_enable = vecs[i].en;
      do_req(vecs[i].id, vecs[i].g, vecs[i].d, vecs[i].idx, vecs[i].fc, 1'b1, 1'b0);
    end

    // Three consecutive denials trigger the lockout.
    id_table = base; id_enable = 4'hF;
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("lock_irq", irq, 1);
    chk("lock_locked", locked, 1);
    req_valid = 1'b1; req_id = 32'hC;
    lock_n = 1; extra = 0; busy = 0;
    for (int k = 0; k < 100 && locked; k++) begin
      @(posedge clk); #1;
      if (locked) begin
        lock_n++;
        if (resp_valid) extra++;
        if (req_ready) busy++;
      end
    end
    $display("lockout lasted %0d cycles", lock_n);
    chk("lock_length", lock_n, 16);
    chk("lock_no_resp", extra, 0);
    chk("lock_not_ready", busy, 0);
    chk("ready_after_lock", req_ready, 1);
    chk("no_resp_after_lock", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("accept_after_lock", req_ready, 0);
    @(posedge clk); #1;
    $display("post-lock req id=0000000c -> valid=%0b granted=%0b index=%0d", resp_valid, resp_granted, resp_index);
    chk("post_lock_valid", resp_valid, 1);
    chk("post_lock_granted", resp_granted, 1);
    chk("post_lock_index", resp_index, 2);
    chk("irq_sticky", irq, 1);

    irq_clear = 1'b1;
    @(posedge clk); #1;
    irq_clear = 1'b0;
    chk("irq_cleared", irq, 0);

    // irq_clear coincides with the edge that sets irq again.
    do_req(32'h777, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    do_req(32'h777, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    do_req(32'h777, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("irq_set_wins", irq, 1);
    irq_clear = 1'b1;
    @(posedge clk); #1;
    irq_clear = 1'b0;
    chk("irq_lone_clear", irq, 0);
    for (int k = 0; k < 40 && locked; k++) begin
      @(posedge clk); #1;
    end
    chk("unlock_timeout", locked, 0);

    // Reset while in CHECK with a nonzero fail count.
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    req_valid = 1'b1; req_id = 32'hC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_check");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst_check", req_ready, 1);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) extra++;
    end
    chk("no_resp_after_rst_check", extra, 0);

    // Reset while LOCKED.
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    do_req(32'h999, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    chk("pre_rst_locked", locked, 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_zero("rst_locked");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst_locked", req_ready, 1);
    extra = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) extra++;
    end
    chk("no_resp_after_rst_locked", extra, 0);
    do_req(32'hC, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
